// File: rtl/bitrev_obi_pkg.sv
// Shared types and helpers for the bit-reversing OBI reader.
// FSM encoding plus the width-parameterised bit reversal.
package bitrev_obi_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_e;

   // Reverse the low w bits of d; bits at and above w come back zero.
   function automatic logic [31:0] bitrev(input logic [31:0] d,
                                          input int unsigned w);
      logic [31:0] r;
      r = '0;
      for (int unsigned i = 0; i < 32; i++)
         if (i < w) r[i[4:0]] = d[5'(w - 1 - i)];
      return r;
   endfunction

endpackage

// File: rtl/bitrev_obi_reader_if.sv
// OBI master bus plus the output stream of the reader.
// master is the reader side, slave is the counter/sink side.
interface bitrev_obi_reader_if #(parameter int W = 32);

   logic          obi_req;
   logic          obi_we;
   logic [3:0]    obi_be;
   logic [31:0]   obi_addr;
   logic [31:0]   obi_wdata;
   logic          obi_gnt;
   logic          obi_rvalid;
   logic [31:0]   obi_rdata;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;

   modport master (
      output obi_req, obi_we, obi_be, obi_addr, obi_wdata,
      input  obi_gnt, obi_rvalid, obi_rdata,
      output out_valid, out_data,
      input  out_ready
   );

   modport slave (
      input  obi_req, obi_we, obi_be, obi_addr, obi_wdata,
      output obi_gnt, obi_rvalid, obi_rdata,
      input  out_valid, out_data,
      output out_ready
   );

endinterface

// File: rtl/bitrev_fifo.sv
// Synchronous FIFO with power-of-two depth and wrapping pointers.
// Caller guarantees no push when full and no pop when empty.
module bitrev_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic [W-1:0]  data_i,
   input  logic          pop_i,
   output logic [W-1:0]  data_o,
   output logic [AW:0]   count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;

   always_comb begin
      wr_d  = wr_q + AW'(push_i);
      rd_d  = rd_q + AW'(pop_i);
      cnt_d = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/bitrev_obi_reader.sv
// Reads the counter over OBI on each trigger edge and queues the
// bit-reversed value for the downstream stream.
module bitrev_obi_reader
   import bitrev_obi_pkg::*;
#(
   parameter int          W         = 32,
   parameter int          DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                en_i,
   input  logic                trig_i,
   bitrev_obi_reader_if.master io,
   output logic                drop_o,
   output logic                busy_o
);

   localparam int          AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   state_e       state_q, state_d;
   logic         trig_q;
   logic         pend_q, pend_d;
   logic         drop_q, drop_d;
   logic         rise, issue, push, pop;
   logic [AW:0]  count;
   logic [W-1:0] wdat;

   // Issuing reserves a FIFO slot, so the later push cannot overflow.
   assign rise   = trig_i & ~trig_q & en_i;
   assign issue  = (state_q == S_IDLE) & pend_q & en_i & (count < FULL);
   assign pend_d = rise | (pend_q & ~issue);
   assign drop_d = rise & pend_q & ~issue;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         trig_q <= 1'b0;
         pend_q <= 1'b0;
         drop_q <= 1'b0;
      end else begin
         trig_q <= trig_i;
         pend_q <= pend_d;
         drop_q <= drop_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (issue)         state_d = S_REQ;
         S_REQ:   if (io.obi_gnt)    state_d = S_WAIT;
         S_WAIT:  if (io.obi_rvalid) state_d = S_IDLE;
         default:                    state_d = S_IDLE;
      endcase
   end

   // Responses outside WAIT are stale and never reach the FIFO.
   always_comb begin
      io.obi_req = 1'b0;
      push       = 1'b0;
      unique case (state_q)
         S_REQ:   io.obi_req = 1'b1;
         S_WAIT:  push       = io.obi_rvalid;
         default: ;
      endcase
   end

   assign io.obi_we    = 1'b0;
   assign io.obi_be    = 4'hF;
   assign io.obi_addr  = BASE_ADDR;
   assign io.obi_wdata = 32'h0;

   assign wdat         = W'(bitrev(io.obi_rdata, W));
   assign io.out_valid = (count != '0);
   assign pop          = io.out_valid & io.out_ready;
   assign drop_o       = drop_q;
   assign busy_o       = (state_q != S_IDLE) | pend_q;

   bitrev_fifo #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .data_i  (wdat),
      .pop_i   (pop),
      .data_o  (io.out_data),
      .count_o (count)
   );

endmodule

// File: tb/tb_bitrev_obi_reader.sv
// Randomised bench for bitrev_obi_reader with an OBI slave model
// and a queue-based reference of the expected stream.
module tb_bitrev_obi_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, en, trig, drop, busy;
   logic trig8, drop8, busy8;

   bitrev_obi_reader_if #(.W(32)) io ();
   bitrev_obi_reader_if #(.W(8))  io8 ();

   bitrev_obi_reader #(.W(32), .DEPTH(4), .BASE_ADDR(32'h10)) u_dut (
      .clk_i (clk), .rst_ni (rst_n), .en_i (en), .trig_i (trig),
      .io (io), .drop_o (drop), .busy_o (busy)
   );

   bitrev_obi_reader #(.W(8), .DEPTH(4), .BASE_ADDR(32'h0)) u_dut8 (
      .clk_i (clk), .rst_ni (rst_n), .en_i (en), .trig_i (trig8),
      .io (io8), .drop_o (drop8), .busy_o (busy8)
   );

   logic       f_push, f_pop;
   logic [7:0] f_din, f_dout;
   logic [2:0] f_cnt;

   bitrev_fifo #(.DEPTH(4), .W(8)) u_fifo (
      .clk_i (clk), .rst_ni (rst_n), .push_i (f_push), .data_i (f_din),
      .pop_i (f_pop), .data_o (f_dout), .count_o (f_cnt)
   );

   int checks = 0, errors = 0;
   int reads = 0, drops = 0, pops = 0, req_cyc = 0, rises = 0;
   logic [31:0] exp_q [$];

   int          gnt_delay = 0, rsp_delay = 1, wait_cnt = 0, rsp_cnt = 0;
   int          rdy_mode = 0;
   bit          rd_rand = 0, rnd_lat = 0, stale = 0;
   logic [31:0] rd_fixed = 32'h1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   // Reference reversal: peel bits off the bottom, stack them up.
   function automatic logic [31:0] ref_rev(input logic [31:0] d,
                                           input int w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < w; i++) r = (r << 1) | ((d >> i) & 32'd1);
      return r;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input int hi, input int lo);
      trig = 1'b1;
      if (en) rises++;
      tick(hi);
      trig = 1'b0;
      tick(lo);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 300) begin
         tick(1);
         n++;
      end
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   // OBI slave for the 32-bit instance
   initial begin
      logic [31:0] d;
      io.obi_gnt = 1'b0;
      io.obi_rvalid = 1'b0;
      io.obi_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         io.obi_rvalid = 1'b0;
         if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
               d = rd_rand ? $urandom : rd_fixed;
               io.obi_rvalid = 1'b1;
               io.obi_rdata = d;
               if (!stale) exp_q.push_back(ref_rev(d, 32));
               stale = 0;
            end
         end
         io.obi_gnt = 1'b0;
         if (io.obi_req) begin
            if (wait_cnt >= gnt_delay) begin
               io.obi_gnt = 1'b1;
               reads++;
               rsp_cnt = rsp_delay;
               wait_cnt = 0;
               if (rnd_lat) begin
                  gnt_delay = $urandom_range(0, 3);
                  rsp_delay = $urandom_range(1, 3);
               end
            end else wait_cnt++;
         end
         if (rdy_mode == 1) io.out_ready = io.obi_rvalid;
         else if (rdy_mode == 2) io.out_ready = 1'($urandom_range(0, 1));
      end
   end

   // OBI slave for the 8-bit instance: grant at once, data next cycle
   initial begin
      logic g8;
      g8 = 1'b0;
      io8.obi_gnt = 1'b0;
      io8.obi_rvalid = 1'b0;
      io8.obi_rdata = 32'hFFFF_FF0D;
      io8.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         io8.obi_rvalid = g8;
         g8 = io8.obi_req;
         io8.obi_gnt = io8.obi_req;
      end
   end

   // Monitor: scoreboard pops, bus attributes, drop pulses
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (io.out_valid && io.out_ready) begin
            pops++;
            if (exp_q.size() == 0) chk("pop_extra", 32'd1, 32'd0);
            else chk("pop_data", io.out_data, exp_q.pop_front());
         end
         if (io.obi_req) begin
            req_cyc++;
            chk("req_addr", io.obi_addr, 32'h10);
            chk("req_we_be", {27'd0, io.obi_we, io.obi_be}, 32'h0F);
            chk("req_wdata", io.obi_wdata, 32'h0);
         end
         if (drop) drops++;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, d0, p0, q0, k0, n;
      logic [31:0] e8;
      logic [7:0]  fv [5];
      rst_n = 1'b0; en = 1'b1; trig = 1'b0; trig8 = 1'b0;
      io.out_ready = 1'b0;
      f_push = 1'b0; f_pop = 1'b0; f_din = 8'h0;
      tick(3);
      chk("rst_req", 32'(io.obi_req), 32'd0);
      chk("rst_be", 32'(io.obi_be), 32'hF);
      chk("rst_addr", io.obi_addr, 32'h10);
      chk("rst_valid", 32'(io.out_valid), 32'd0);
      chk("rst_drop", 32'(drop), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(2);

      // basic read and minimum latency
      rd_fixed = 32'h1;
      trig = 1'b1;
      rises++;
      repeat (2) @(negedge clk);
      trig = 1'b0;
      repeat (2) @(negedge clk);
      chk("lat_early", 32'(io.out_valid), 32'd0);
      @(negedge clk);
      chk("lat_valid", 32'(io.out_valid), 32'd1);
      chk("lat_data", io.out_data, 32'h8000_0000);
      chk("lat_reads", reads, 1);
      tick(1);
      io.out_ready = 1'b1;
      tick(1);
      io.out_ready = 1'b0;

      // W=8 instance
      trig8 = 1'b1;
      tick(2);
      trig8 = 1'b0;
      n = 0;
      while (!io8.out_valid && n < 20) begin
         tick(1);
         n++;
      end
      e8 = ref_rev(32'hFFFF_FF0D, 8);
      chk("w8_valid", 32'(io8.out_valid), 32'd1);
      chk("w8_data", 32'(io8.out_data), e8);
      chk("w8_const", 32'(io8.out_data), 32'hB0);

      // backpressure: fifo fills, fifth trigger waits
      rd_rand = 1;
      r0 = reads; d0 = drops; p0 = pops;
      repeat (5) pulse(1, 10);
      tick(5);
      chk("bp_reads4", reads - r0, 4);
      chk("bp_noreq", 32'(io.obi_req), 32'd0);
      chk("bp_pend", 32'(busy), 32'd1);
      chk("bp_drops", drops - d0, 0);
      io.out_ready = 1'b1;
      wait_idle("bp");
      tick(10);
      chk("bp_reads5", reads - r0, 5);
      chk("bp_pops", pops - p0, 5);
      chk("bp_empty", 32'(io.out_valid), 32'd0);
      io.out_ready = 1'b0;

      // push and pop together at count DEPTH-1
      r0 = reads; p0 = pops;
      repeat (3) pulse(1, 8);
      rdy_mode = 1;
      pulse(1, 8);
      rdy_mode = 0;
      io.out_ready = 1'b0;
      pulse(1, 8);
      pulse(1, 8);
      chk("pp_reads", reads - r0, 5);
      chk("pp_held", 32'(busy), 32'd1);
      chk("pp_noreq", 32'(io.obi_req), 32'd0);
      io.out_ready = 1'b1;
      wait_idle("pp");
      tick(10);
      chk("pp_pops", pops - p0, 6);

      // collision: edge in WAIT sets pend, next edge drops
      r0 = reads; d0 = drops;
      rsp_delay = 5;
      repeat (3) pulse(1, 1);
      rsp_delay = 1;
      wait_idle("col");
      tick(4);
      chk("col_drops", drops - d0, 1);
      chk("col_reads", reads - r0, 2);

      // delayed grant: request held for the whole wait
      q0 = req_cyc;
      gnt_delay = 5;
      pulse(1, 3);
      wait_idle("dg");
      gnt_delay = 0;
      tick(4);
      chk("dg_reqcyc", req_cyc - q0, 6);

      // enable dropped mid-transaction
      r0 = reads; d0 = drops;
      gnt_delay = 3;
      pulse(1, 1);
      pulse(1, 1);
      en = 1'b0;
      gnt_delay = 0;
      tick(10);
      pulse(1, 1);
      chk("en_reads1", reads - r0, 1);
      chk("en_pend", 32'(busy), 32'd1);
      chk("en_noreq", 32'(io.obi_req), 32'd0);
      en = 1'b1;
      wait_idle("en");
      tick(4);
      chk("en_reads2", reads - r0, 2);
      chk("en_drops", drops - d0, 0);

      // reset while waiting for the response
      io.out_ready = 1'b0;
      rsp_delay = 6;
      pulse(1, 1);
      tick(2);
      exp_q.delete();
      stale = 1;
      rst_n = 1'b0;
      #1;
      chk("rr_req", 32'(io.obi_req), 32'd0);
      tick(1);
      rst_n = 1'b1;
      rsp_delay = 1;
      tick(8);
      chk("rr_valid", 32'(io.out_valid), 32'd0);
      chk("rr_busy", 32'(busy), 32'd0);

      // fifo alone: push and pop together while full
      for (int i = 0; i < 5; i++) fv[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) begin
         f_push = 1'b1;
         f_din = fv[i];
         tick(1);
      end
      f_push = 1'b0;
      chk("ff_full", 32'(f_cnt), 32'd4);
      f_push = 1'b1; f_pop = 1'b1; f_din = fv[4];
      tick(1);
      f_push = 1'b0; f_pop = 1'b0;
      chk("ff_keep", 32'(f_cnt), 32'd4);
      for (int i = 1; i < 5; i++) begin
         chk("ff_order", 32'(f_dout), 32'(fv[i]));
         f_pop = 1'b1;
         tick(1);
      end
      f_pop = 1'b0;
      chk("ff_empty", 32'(f_cnt), 32'd0);

      // random traffic: triggers, latencies, ready
      r0 = reads; d0 = drops; p0 = pops; k0 = rises;
      rnd_lat = 1;
      rdy_mode = 2;
      repeat (40) pulse($urandom_range(1, 4), $urandom_range(1, 8));
      rdy_mode = 0;
      rnd_lat = 0;
      io.out_ready = 1'b1;
      wait_idle("rnd");
      gnt_delay = 0;
      rsp_delay = 1;
      tick(10);
      chk("rnd_acct", (reads - r0) + (drops - d0), rises - k0);
      chk("rnd_pops", pops - p0, reads - r0);
      chk("rnd_empty", 32'(io.out_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
